// File: rtl/key_pkg.sv
// Shared types and widths for the two-channel key conditioner.
package key_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce counter and press/repeat FSM.
// Exposes next-cycle level and strobe so the top can register and mask them.
module key_channel
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE     = 32'd500000,
    parameter logic [CNT_W-1:0] REPEAT_DELAY = 32'd25000000,
    parameter logic [CNT_W-1:0] REPEAT_RATE  = 32'd5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_level_nxt_c,
    output logic o_pulse_c
);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_level;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic             w_level_nxt;

    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_rcnt_nxt;
    logic             w_pulse_nxt;

    // Level flips only after DEBOUNCE consecutive disagreeing cycles.
    always_comb begin
        w_level_nxt = r_level;
        w_dcnt_nxt  = '0;
        if (r_sync2 != r_level) begin
            if (r_dcnt == DEBOUNCE - CNT_W'(1)) begin
                w_level_nxt = r_sync2;
            end else begin
                w_dcnt_nxt = r_dcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_dcnt  <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_dcnt  <= w_dcnt_nxt;
            r_level <= w_level_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // FSM decides on the next level so the strobe lines up with the level edge.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_level && !w_level_nxt) begin
                    w_pulse_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_level_nxt) begin
                    w_state_nxt = IDLE;
                end else if ((REPEAT_DELAY != '0) &&
                             (r_rcnt == REPEAT_DELAY - CNT_W'(1))) begin
                    w_pulse_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = REPEAT;
                end else begin
                    w_rcnt_nxt = r_rcnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (w_level_nxt) begin
                    w_state_nxt = IDLE;
                end else if (r_rcnt == REPEAT_RATE - CNT_W'(1)) begin
                    w_pulse_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    assign o_level_nxt_c = w_level_nxt;
    assign o_pulse_c     = w_pulse_nxt;

endmodule

// File: rtl/key_debounce.sv
// Up/down key conditioner: debounced active-low levels plus press/repeat strobes.
// Up wins: a down strobe is dropped in any cycle where up_n reads 0.
module key_debounce
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE     = 32'd500000,
    parameter logic [CNT_W-1:0] REPEAT_DELAY = 32'd25000000,
    parameter logic [CNT_W-1:0] REPEAT_RATE  = 32'd5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_up_n,
    input  logic key_down_n,
    output logic up_n,
    output logic down_n,
    output logic up_pulse,
    output logic down_pulse
);

    logic w_up_level_nxt;
    logic w_up_pulse_nxt;
    logic w_dn_level_nxt;
    logic w_dn_pulse_nxt;

    logic r_up_n;
    logic r_down_n;
    logic r_up_pulse;
    logic r_down_pulse;

    key_channel #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_up (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_key_n       (key_up_n),
        .o_level_nxt_c (w_up_level_nxt),
        .o_pulse_c     (w_up_pulse_nxt)
    );

    key_channel #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_down (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_key_n       (key_down_n),
        .o_level_nxt_c (w_dn_level_nxt),
        .o_pulse_c     (w_dn_pulse_nxt)
    );

    // Mask uses up's next level, i.e. the up_n value visible alongside the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_n       <= 1'b1;
            r_down_n     <= 1'b1;
            r_up_pulse   <= 1'b0;
            r_down_pulse <= 1'b0;
        end else begin
            r_up_n       <= w_up_level_nxt;
            r_down_n     <= w_dn_level_nxt;
            r_up_pulse   <= w_up_pulse_nxt;
            r_down_pulse <= w_dn_pulse_nxt & w_up_level_nxt;
        end
    end

    assign up_n       = r_up_n;
    assign down_n     = r_down_n;
    assign up_pulse   = r_up_pulse;
    assign down_pulse = r_down_pulse;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_RATE=3, plus a
// second instance with REPEAT_DELAY=0. Output vector {up_n,down_n,up_p,down_p} x2.
module tb_key_debounce;

    typedef struct {
        logic       up_in;
        logic [3:0] exp;
    } vec_t;

    localparam logic [3:0] IDLE_O = 4'b1100;

    logic clk = 1'b0;
    logic rst_n;
    logic ku, kd, ku0, kd0;
    logic up_n, down_n, up_p, down_p;
    logic up_n0, down_n0, up_p0, down_p0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    vec_t        tbl[14];

    always #5 clk = ~clk;

    key_debounce #(
        .DEBOUNCE(32'd4), .REPEAT_DELAY(32'd10), .REPEAT_RATE(32'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_up_n(ku), .key_down_n(kd),
        .up_n(up_n), .down_n(down_n), .up_pulse(up_p), .down_pulse(down_p)
    );

    key_debounce #(
        .DEBOUNCE(32'd4), .REPEAT_DELAY(32'd0), .REPEAT_RATE(32'd3)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .key_up_n(ku0), .key_down_n(kd0),
        .up_n(up_n0), .down_n(down_n0), .up_pulse(up_p0), .down_pulse(down_p0)
    );

    function automatic logic [7:0] act_vec();
        return {up_n, down_n, up_p, down_p, up_n0, down_n0, up_p0, down_p0};
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive inputs for the next edge, queue the expectation, compare after the edge.
    task automatic step(input string name, input int idx,
                        input logic u, input logic d, input logic u0, input logic d0,
                        input logic [7:0] exp);
        logic [7:0] e;
        ku = u; kd = d; ku0 = u0; kd0 = d0;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_empty_q"}, idx, 8'h00, 8'hff);
        end else begin
            e = exp_q.pop_front();
            check(name, idx, act_vec(), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       u, d, dn, dp, un, upl;
        int         off;

        tbl = '{
            '{1'b0, 4'b1100}, '{1'b0, 4'b1100}, '{1'b0, 4'b1100},
            '{1'b0, 4'b1100}, '{1'b0, 4'b1100}, '{1'b0, 4'b0110},
            '{1'b0, 4'b0100}, '{1'b1, 4'b0100}, '{1'b1, 4'b0100},
            '{1'b1, 4'b0100}, '{1'b1, 4'b0100}, '{1'b1, 4'b0100},
            '{1'b1, 4'b1100}, '{1'b1, 4'b1100}
        };

        ku = 1'b1; kd = 1'b1; ku0 = 1'b1; kd0 = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 0, act_vec(), {IDLE_O, IDLE_O});
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press and release on up
        for (int i = 0; i < 14; i++) begin
            step("clean_press", i + 1, tbl[i].up_in, 1'b1, 1'b1, 1'b1, {tbl[i].exp, IDLE_O});
        end

        // Bouncy down press: 2-cycle glitches, then stable low, then release
        for (int k = 1; k <= 24; k++) begin
            if (k <= 8) d = ((k - 1) % 4) >= 2;
            else        d = (k >= 17);
            dn = !(k >= 14 && k <= 21);
            dp = (k == 14);
            step("bounce", k, 1'b1, d, 1'b1, 1'b1, {1'b1, dn, 1'b0, dp, IDLE_O});
        end

        // Auto-repeat on up: raw release at step 31, debounced at step 36
        for (int k = 1; k <= 45; k++) begin
            u   = (k > 30);
            un  = !(k >= 6 && k <= 35);
            off = k - 6;
            upl = (off == 0) || (off >= 10 && off <= 28 && ((off - 10) % 3) == 0);
            step("auto_repeat", k, u, 1'b1, 1'b1, 1'b1, {un, 1'b1, upl, 1'b0, IDLE_O});
        end

        // REPEAT_DELAY=0 instance: long down hold gives a single strobe
        for (int k = 1; k <= 58; k++) begin
            d  = (k > 50);
            dn = !(k >= 6 && k <= 55);
            dp = (k == 6);
            step("no_repeat", k, 1'b1, 1'b1, 1'b1, d, {IDLE_O, 1'b1, dn, 1'b0, dp});
        end

        // Both keys: down strobes masked while up held, resume on down's schedule
        for (int k = 1; k <= 44; k++) begin
            u   = (k >= 20);
            d   = !(k >= 3 && k <= 33);
            un  = !(k >= 6 && k <= 24);
            upl = (k == 6) || (k == 16) || (k == 19) || (k == 22);
            dn  = !(k >= 8 && k <= 38);
            dp  = (k >= 27 && k <= 36 && ((k - 27) % 3) == 0);
            step("both_held", k, u, d, 1'b1, 1'b1, {un, dn, upl, dp, IDLE_O});
        end

        // Reset while up is in HOLD, key still held through reset release
        for (int k = 1; k <= 8; k++) begin
            step("pre_reset", k, 1'b0, 1'b1, 1'b1, 1'b1,
                 {(k < 6), 1'b1, (k == 6), 1'b0, IDLE_O});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 0, act_vec(), {IDLE_O, IDLE_O});
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step("post_reset", k, 1'b0, 1'b1, 1'b1, 1'b1,
                 {(k < 6), 1'b1, (k == 6), 1'b0, IDLE_O});
        end
        for (int k = 1; k <= 8; k++) begin
            step("post_reset_rel", k, 1'b1, 1'b1, 1'b1, 1'b1,
                 {(k >= 6), 1'b1, 1'b0, 1'b0, IDLE_O});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
